// File: rtl/cache_bus_pkg.sv
// Shared type codes, line geometry and FSM state types for the cache memory bus.
package cache_bus_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam int unsigned LINE_BEATS = 4;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_BURST
  } rd_state_e;

  typedef enum logic {
    W_IDLE,
    W_BUSY
  } wr_state_e;

endpackage

// File: rtl/resp_bank_ram.sv
// One word-wide memory bank: byte-enabled synchronous write, asynchronous read.
module resp_bank_ram #(
  parameter int unsigned AddrW = 8
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [AddrW-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [2**AddrW];

  // Byte-lane writes; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill/write-back bus. Four interleaved banks
// (one per word-in-line) let a whole line be written in one cycle; reads are returned
// as 1- or 4-beat bursts after a fixed latency.
module cache_mem_responder
  import cache_bus_pkg::*;
#(
  parameter int unsigned MEM_WORDS_LOG2 = 10,
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned WR_LATENCY     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy
);

  localparam int unsigned AW     = MEM_WORDS_LOG2;
  localparam int unsigned RowW   = MEM_WORDS_LOG2 - 2;
  localparam int unsigned RCntW  = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
  localparam int unsigned WCntW  = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;

  // Byte offset and out-of-range address bits; addresses wrap modulo memory size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};

  // ---------------------------------------------------------------- banks
  logic [3:0]  bank_we    [LINE_BEATS];
  logic [31:0] bank_wdata [LINE_BEATS];
  logic [31:0] bank_rdata [LINE_BEATS];
  logic [AW-1:0] sample_addr;

  for (genvar b = 0; b < LINE_BEATS; b++) begin : g_bank
    resp_bank_ram #(
      .AddrW(RowW)
    ) u_bank (
      .clk  (clk),
      .we   (bank_we[b]),
      .waddr(wr_addr[AW+1:4]),
      .wdata(bank_wdata[b]),
      .raddr(sample_addr[AW-1:2]),
      .rdata(bank_rdata[b])
    );
  end

  // ---------------------------------------------------------------- write side
  wr_state_e        w_state_q, w_state_d;
  logic [WCntW-1:0] w_cnt_q, w_cnt_d;
  logic             wr_accept;
  logic             wr_line;

  assign wr_rdy    = (w_state_q == W_IDLE);
  assign wr_accept = wr_req && wr_rdy;
  assign wr_line   = (wr_type == TYPE_LINE);

  // Bank write enables: line writes hit all banks, others one bank under strobes.
  always_comb begin
    for (int b = 0; b < LINE_BEATS; b++) begin
      bank_we[b]    = '0;
      bank_wdata[b] = wr_data[32*b +: 32];
      if (wr_accept) begin
        if (wr_line) begin
          bank_we[b] = 4'hF;
        end else if (wr_addr[3:2] == 2'(b)) begin
          bank_we[b]    = wr_wstrb;
          bank_wdata[b] = wr_data[31:0];
        end
      end
    end
  end

  // Write FSM next state: hold wr_rdy low for WR_LATENCY cycles after an accept.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (wr_accept && (WR_LATENCY > 0)) begin
          w_state_d = W_BUSY;
          w_cnt_d   = '0;
        end
      end
      W_BUSY: begin
        if (w_cnt_q == WCntW'(WR_LATENCY - 1)) begin
          w_state_d = W_IDLE;
        end else begin
          w_cnt_d = w_cnt_q + 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  // ---------------------------------------------------------------- read side
  rd_state_e        rd_state_q, rd_state_d;
  logic [RCntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;   // word address of the beat being presented
  logic             rd_line_q, rd_line_d;
  logic [31:0]      ret_data_q;
  logic             rd_accept;
  logic             rd_line;
  logic [AW-1:0]    rd_word;
  logic [AW-1:0]    rd_start;

  assign rd_rdy    = (rd_state_q == R_IDLE);
  assign rd_accept = rd_req && rd_rdy;
  assign rd_line   = (rd_type == TYPE_LINE);
  assign rd_word   = rd_addr[AW+1:2];
  assign rd_start  = rd_line ? {rd_word[AW-1:2], 2'b00} : rd_word;

  assign ret_valid = (rd_state_q == R_BURST);
  assign ret_last  = ret_valid && (!rd_line_q || (rd_ptr_q[1:0] == 2'd3));
  assign ret_data  = ret_data_q;

  // Read FSM next state; sample_addr is the word registered into ret_data this cycle.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_cnt_d    = rd_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_line_d   = rd_line_q;
    sample_addr = rd_ptr_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (rd_accept) begin
          rd_ptr_d    = rd_start;
          rd_line_d   = rd_line;
          rd_cnt_d    = '0;
          sample_addr = rd_start;
          rd_state_d  = (RD_LATENCY > 1) ? R_WAIT : R_BURST;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == RCntW'(RD_LATENCY - 2)) begin
          rd_state_d = R_BURST;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      R_BURST: begin
        sample_addr = {rd_ptr_q[AW-1:2], rd_ptr_q[1:0] + 2'd1};
        if (ret_last) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_ptr_d = sample_addr;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read FSM state and registered return data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      rd_line_q  <= 1'b0;
      ret_data_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_line_q  <= rd_line_d;
      if (rd_state_d == R_BURST) begin
        ret_data_q <= bank_rdata[sample_addr[1:0]];
      end
    end
  end

endmodule
